decode_stage: RTL

- Pipelined RV32I instruction-decode stage with a parametrised instruction buffer, a registered control bundle, valid/ready handshakes on both sides, a flush input and illegal-opcode flagging.
- Sits between fetch and execute.
- Replaces purely combinational control decode with a buffered, back-pressure-aware stage.

---
 rtl/decode_stage_if.sv | 45 ++++
 rtl/decode_stage.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
interface decode_stage_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rd;
  logic [4:0]      out_rs1;
  logic [4:0]      out_rs2;
  logic [3:0]      out_aluop;
  logic            out_immsrc;
  logic            out_isbranch;
  logic            out_memread;
  logic            out_memwrite;
  logic            out_regwrite;
  logic            out_pcsel;
  logic            out_rdsel;
  logic            out_isjump;
  logic            out_islui;
  logic            out_use_rs1;
  logic            out_use_rs2;
  logic            out_illegal;
  logic [1:0]      out_memtoreg;

  modport master (
    output in_valid, in_inst, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_aluop,
           out_immsrc, out_isbranch, out_memread, out_memwrite, out_regwrite,
           out_pcsel, out_rdsel, out_isjump, out_islui, out_use_rs1,
           out_use_rs2, out_illegal, out_memtoreg
  );

  modport slave (
    input  in_valid, in_inst, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_rd, out_rs1, out_rs2, out_aluop,
           out_immsrc, out_isbranch, out_memread, out_memwrite, out_regwrite,
           out_pcsel, out_rdsel, out_isjump, out_islui, out_use_rs1,
           out_use_rs2, out_illegal, out_memtoreg
  );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction FIFO, combinational decode of the head, registered bundle.
// Optional load-use bubble enabled by defining DECODE_LOAD_USE_INTERLOCK_EN.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  decode_stage_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [3:0]      aluop;
    logic            immsrc;
    logic            isbranch;
    logic            memread;
    logic            memwrite;
    logic            regwrite;
    logic            pcsel;
    logic            rdsel;
    logic            isjump;
    logic            islui;
    logic            use_rs1;
    logic            use_rs2;
    logic            illegal;
    logic [1:0]      memtoreg;
  } bundle_t;

  logic [AW:0]     wr_ptr, rd_ptr;
  logic [31:0]     inst_mem [DEPTH];
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     head_inst;
  logic [2:0]      f3;
  logic            f7_alt;
  logic            full, empty, push, pop, fire, valid_q, out_valid_w;
  bundle_t         dec, out_q;

  function automatic logic [3:0] alu_map(input logic [2:0] funct3, input logic alt);
    case (funct3)
      3'd0:    return alt ? 4'd1 : 4'd0;
      3'd1:    return 4'd5;
      3'd2:    return 4'd8;
      3'd3:    return 4'd9;
      3'd4:    return 4'd2;
      3'd5:    return alt ? 4'd7 : 4'd6;
      3'd6:    return 4'd3;
      default: return 4'd4;
    endcase
  endfunction

  // Full when pointers differ only in the wrap bit.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign push  = bus.in_valid && !full;
  assign fire  = out_valid_w && bus.out_ready;
  assign pop   = !empty && (!valid_q || fire);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush) begin
      inst_mem[wr_ptr[AW-1:0]] <= bus.in_inst;
      pc_mem[wr_ptr[AW-1:0]]   <= bus.in_pc;
    end
  end

  assign head_inst = inst_mem[rd_ptr[AW-1:0]];
  assign f3        = head_inst[14:12];
  assign f7_alt    = (head_inst[31:25] == 7'h20);

  always_comb begin
    dec     = '0;
    dec.pc  = pc_mem[rd_ptr[AW-1:0]];
    dec.rd  = head_inst[11:7];
    dec.rs1 = head_inst[19:15];
    dec.rs2 = head_inst[24:20];
    case (head_inst[6:0])
      7'h33: begin
        dec.aluop    = alu_map(f3, f7_alt);
        dec.regwrite = 1'b1;
        dec.memtoreg = 2'd2;
        dec.use_rs1  = 1'b1;
        dec.use_rs2  = 1'b1;
      end
      7'h13: begin
        // addi has no subtract form; the funct7 alternate only selects srai.
        dec.aluop    = alu_map(f3, f7_alt && (f3 != 3'd0));
        dec.immsrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.memtoreg = 2'd2;
        dec.use_rs1  = 1'b1;
      end
      7'h03: begin
        dec.memread  = 1'b1;
        dec.immsrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.memtoreg = 2'd1;
        dec.use_rs1  = 1'b1;
      end
      7'h23: begin
        dec.memwrite = 1'b1;
        dec.immsrc   = 1'b1;
        dec.use_rs1  = 1'b1;
        dec.use_rs2  = 1'b1;
      end
      7'h63: begin
        dec.isbranch = 1'b1;
        dec.aluop    = f3[2] && f3[1] ? 4'd9 : 4'd8;
        dec.use_rs1  = 1'b1;
        dec.use_rs2  = 1'b1;
      end
      7'h6f: begin
        dec.immsrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.isjump   = 1'b1;
      end
      7'h67: begin
        dec.immsrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.isjump   = 1'b1;
        dec.pcsel    = 1'b1;
        dec.use_rs1  = 1'b1;
      end
      7'h37: begin
        dec.immsrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.islui    = 1'b1;
        dec.memtoreg = 2'd2;
      end
      7'h17: begin
        dec.immsrc   = 1'b1;
        dec.regwrite = 1'b1;
        dec.rdsel    = 1'b1;
      end
      7'h73: begin
        if (f3[1:0] != 2'd0) begin
          dec.regwrite = 1'b1;
          dec.memtoreg = 2'd3;
          dec.use_rs1  = !f3[2];
          dec.immsrc   = f3[2];
        end
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      out_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (pop) begin
      valid_q <= 1'b1;
      out_q   <= dec;
    end else if (fire) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DECODE_LOAD_USE_INTERLOCK_EN
  logic       ld_pend_q;
  logic [4:0] ld_rd_q;
  logic       hazard;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ld_pend_q <= 1'b0;
      ld_rd_q   <= '0;
    end else if (flush) begin
      ld_pend_q <= 1'b0;
      ld_rd_q   <= '0;
    end else begin
      ld_pend_q <= fire && out_q.memread && (out_q.rd != 5'd0);
      ld_rd_q   <= out_q.rd;
    end
  end

  assign hazard = ld_pend_q && valid_q &&
                  ((out_q.use_rs1 && (out_q.rs1 == ld_rd_q)) ||
                   (out_q.use_rs2 && (out_q.rs2 == ld_rd_q)));
  assign out_valid_w = valid_q && !hazard;
`else
  assign out_valid_w = valid_q;
`endif

  assign bus.in_ready     = !full;
  assign bus.out_valid    = out_valid_w;
  assign bus.out_pc       = out_q.pc;
  assign bus.out_rd       = out_q.rd;
  assign bus.out_rs1      = out_q.rs1;
  assign bus.out_rs2      = out_q.rs2;
  assign bus.out_aluop    = out_q.aluop;
  assign bus.out_immsrc   = out_q.immsrc;
  assign bus.out_isbranch = out_q.isbranch;
  assign bus.out_memread  = out_q.memread;
  assign bus.out_memwrite = out_q.memwrite;
  assign bus.out_regwrite = out_q.regwrite;
  assign bus.out_pcsel    = out_q.pcsel;
  assign bus.out_rdsel    = out_q.rdsel;
  assign bus.out_isjump   = out_q.isjump;
  assign bus.out_islui    = out_q.islui;
  assign bus.out_use_rs1  = out_q.use_rs1;
  assign bus.out_use_rs2  = out_q.use_rs2;
  assign bus.out_illegal  = out_q.illegal;
  assign bus.out_memtoreg = out_q.memtoreg;
endmodule
